// File: rtl/nbout_pkg.sv
// Shared widths and FSM state type for the NBout packer control slice.
package nbout_pkg;

  localparam int unsigned BIT_WIDTH  = 16;
  localparam int unsigned SHIFT_BITS = 5;
  localparam int unsigned BIT_IDX    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/nbout_pack_mask.sv
// Builds the packer load mask: 'width' ones starting at bit 'base', wrapping
// around the two concatenated rows.
module nbout_pack_mask
  import nbout_pkg::*;
(
  input  logic [SHIFT_BITS-1:0]  width,
  input  logic [SHIFT_BITS-1:0]  base,
  output logic [2*BIT_WIDTH-1:0] mask
);

  logic [SHIFT_BITS-1:0] idx;

  // Index arithmetic is modulo 2*BIT_WIDTH by truncation, which yields the rotate.
  always_comb begin
    mask = '0;
    idx  = '0;
    for (int unsigned i = 0; i < 2*BIT_WIDTH; i++) begin
      idx       = SHIFT_BITS'(i) + base;
      mask[idx] = (SHIFT_BITS'(i) < width);
    end
  end

endmodule

// File: rtl/nbout_pack_ctrl.sv
// Control sequencer for nbout_packer: tracks the bit pointer across two rows
// and issues one NBout write per completed or flushed row.
module nbout_pack_ctrl
  import nbout_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [BIT_IDX-1:0]     i_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_flush,
  output logic [SHIFT_BITS-1:0]  o_s,
  output logic [2*BIT_WIDTH-1:0] o_load,
  output logic                   o_row_sel,
  output logic                   o_wr_en,
  input  logic                   i_wr_ready,
  output logic [SHIFT_BITS-1:0]  o_wr_len,
  output logic                   o_busy,
  output logic                   o_done
);

  state_t                  state;
  logic [SHIFT_BITS-2:0]   ptr;
  logic                    row;
  logic [SHIFT_BITS-1:0]   width;
  logic [SHIFT_BITS-1:0]   base;
  logic [SHIFT_BITS-1:0]   p_next;
  logic [2*BIT_WIDTH-1:0]  mask;
  logic                    pending;
  logic                    accept;

  assign base    = {row, ptr};
  assign pending = o_wr_en & ~i_wr_ready;
  assign o_ready = (state == RUN) & ~pending;
  assign accept  = o_ready & i_valid;
  assign p_next  = {1'b0, ptr} + width;
  assign o_busy  = (state != IDLE);
  assign o_s     = accept ? base : '0;
  assign o_load  = accept ? mask : '0;

  nbout_pack_mask u_mask (
    .width (width),
    .base  (base),
    .mask  (mask)
  );

  // BIT_WIDTH is a power of two, so p_next's MSB flags row completion and the
  // low bits are already p_next - BIT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      row       <= 1'b0;
      width     <= SHIFT_BITS'(1);
      o_wr_en   <= 1'b0;
      o_row_sel <= 1'b0;
      o_wr_len  <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (o_wr_en && i_wr_ready) o_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            width <= SHIFT_BITS'(i_n) + SHIFT_BITS'(1);
            ptr   <= '0;
            row   <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            ptr <= p_next[SHIFT_BITS-2:0];
            if (p_next[SHIFT_BITS-1]) begin
              row       <= ~row;
              o_wr_en   <= 1'b1;
              o_row_sel <= row;
              o_wr_len  <= SHIFT_BITS'(BIT_WIDTH);
            end
          end
          if (i_flush) state <= FLUSH;
        end
        FLUSH: begin
          if (!pending) begin
            if (ptr != '0) begin
              o_wr_en   <= 1'b1;
              o_row_sel <= row;
              o_wr_len  <= {1'b0, ptr};
              ptr       <= '0;
              row       <= ~row;
            end
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pending) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbout_pack_ctrl.sv
// Self-checking bench for nbout_pack_ctrl against a bit-position reference model.
module tb_nbout_pack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [3:0]  i_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_flush;
  logic [4:0]  o_s;
  logic [31:0] o_load;
  logic        o_row_sel;
  logic        o_wr_en;
  logic        i_wr_ready;
  logic [4:0]  o_wr_len;
  logic        o_busy;
  logic        o_done;

  always #5 clk = ~clk;

  nbout_pack_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_n        (i_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_flush    (i_flush),
    .o_s        (o_s),
    .o_load     (o_load),
    .o_row_sel  (o_row_sel),
    .o_wr_en    (o_wr_en),
    .i_wr_ready (i_wr_ready),
    .o_wr_len   (o_wr_len),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  typedef struct packed {
    logic       row;
    logic [4:0] len;
  } wr_t;

  int  vectors = 0;
  int  errs    = 0;
  wr_t wq[$];
  int  mpos  = 0;   // absolute bit position within the 32-bit row pair
  int  mw    = 1;
  bit  mrun  = 0;
  bit  midle = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input int b, input int w);
    logic [63:0] x;
    x = ((64'd1 << w) - 64'd1) << b;
    return x[31:0] | x[63:32];
  endfunction

  task automatic check_write();
    wr_t e;
    if (wq.size() == 0) begin
      chk("unexpected_write", 32'd1, 32'd0);
    end else begin
      e = wq.pop_front();
      chk("wr_row_sel", 32'(o_row_sel), 32'(e.row));
      chk("wr_len", 32'(o_wr_len), 32'(e.len));
    end
  endtask

  // One cycle: drive inputs after negedge, check, advance the model, wait next negedge.
  task automatic tick(input bit valid, input bit wrr, input bit flush, input bit start);
    bit exp_ready, acc;
    wr_t e;
    i_valid = valid; i_wr_ready = wrr; i_flush = flush; i_start = start;
    #1;
    exp_ready = mrun && !(wq.size() > 0 && !wrr);
    acc = exp_ready && valid;
    chk("ready", 32'(o_ready), 32'(exp_ready));
    chk("wr_en", 32'(o_wr_en), 32'(wq.size() > 0));
    chk("busy", 32'(o_busy), 32'(!midle));
    chk("done_idle", 32'(o_done), 32'd0);
    if (acc) begin
      chk("s", 32'(o_s), 32'(mpos));
      chk("load", o_load, exp_load(mpos, mw));
    end else begin
      chk("load_zero", o_load, 32'd0);
    end
    if (o_wr_en && wrr) check_write();
    if (acc) begin
      if ((mpos % 16) + mw >= 16) begin
        e.row = 1'((mpos / 16) % 2); e.len = 5'd16; wq.push_back(e);
      end
      mpos = (mpos + mw) % 32;
    end
    if (mrun && flush) begin
      mrun = 0;
      if (mpos % 16 != 0) begin
        e.row = 1'((mpos / 16) % 2); e.len = 5'(mpos % 16); wq.push_back(e);
      end
    end
    if (midle && start) begin
      midle = 0; mrun = 1; mpos = 0; mw = int'(i_n) + 1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      i_valid = 1'($urandom % 2); i_wr_ready = (($urandom % 4) != 0);
      i_flush = 0; i_start = 0;
      #1;
      chk("drain_ready", 32'(o_ready), 32'd0);
      chk("drain_load", o_load, 32'd0);
      if (o_wr_en && i_wr_ready) check_write();
      if (o_done) begin
        seen = 1;
        chk("done_busy", 32'(o_busy), 32'd0);
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("drain_q_empty", 32'(wq.size()), 32'd0);
    wq.delete();
    i_valid = 0; i_wr_ready = 1;
    #1;
    chk("done_pulse_len", 32'(o_done), 32'd0);
    midle = 1;
    @(negedge clk);
  endtask

  task automatic start_layer(input int n);
    i_n = 4'(n);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 0; i_start = 0; i_n = 0; i_valid = 0; i_flush = 0; i_wr_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_len", 32'(o_wr_len), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Full-width neurons, one write per neuron
    start_layer(15);
    repeat (4) tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    drain();

    // Byte neurons
    start_layer(7);
    repeat (4) tick(1, 1, 0, 0);
    tick(0, 1, 1, 0);
    drain();

    // 5-bit neurons crossing the row boundary and wrapping bit 31->0
    start_layer(4);
    repeat (7) tick(1, 1, 0, 0);
    tick(0, 1, 1, 0);
    drain();

    // Backpressure on the write port
    start_layer(15);
    repeat (2) tick(1, 1, 0, 0);
    repeat (3) tick(1, 0, 0, 0);
    repeat (3) tick(1, 1, 0, 0);
    tick(0, 1, 1, 0);
    drain();

    // Partial-row flush, then a flush with an empty pointer
    start_layer(4);
    repeat (2) tick(1, 1, 0, 0);
    tick(0, 1, 1, 0);
    drain();
    start_layer(4);
    tick(0, 1, 1, 0);
    drain();

    // Reset mid-row
    start_layer(7);
    tick(1, 1, 0, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_ready", 32'(o_ready), 32'd0);
    chk("mid_rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("mid_rst_row_sel", 32'(o_row_sel), 32'd0);
    chk("mid_rst_len", 32'(o_wr_len), 32'd0);
    chk("mid_rst_load", o_load, 32'd0);
    chk("mid_rst_s", 32'(o_s), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    wq.delete(); mrun = 0; midle = 1; mpos = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    start_layer(7);
    repeat (3) tick(1, 1, 0, 0);
    // i_start inside RUN must not change precision or pointer
    i_n = 4'd9;
    tick(1, 1, 0, 1);
    tick(1, 1, 1, 0);
    drain();

    // Randomized layers with random valid / write-ready
    for (int l = 0; l < 8; l++) begin
      start_layer(int'($urandom_range(0, 15)));
      for (int c = 0; c < 24; c++)
        tick(($urandom % 10) < 7, ($urandom % 4) != 0, 1'b0, 1'b0);
      tick(1'($urandom % 2), 1'($urandom % 2), 1'b1, 1'b0);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
